// File: rtl/ping_pong_monitor.sv
// ---------------------------------------------------------------------------
// ping_pong_monitor
//   Receive-side checker for a ping-pong counter stream (value + direction).
//   When enable is high it samples the stream, predicts the next sample from
//   the last accepted one and flags any deviation. It also reports top and
//   bottom bounces and counts completed laps. A lap is one bottom bounce.
//
//   Optional feature: define PP_MON_ERR_CNT_EN to add the saturating err_cnt
//   port and its logic. With the macro undefined, the port and logic are absent.
//
// Ports
//   clk        in   1      single clock, all logic on posedge
//   rst        in   1      synchronous reset, active-high
//   enable     in   1      sample strobe; stream observed only when 1
//   direction  in   1      observed direction (1 = up, 0 = down)
//   cnt_in     in   WIDTH  observed counter value
//   clr        in   1      clears err_flag, lap_cnt (and err_cnt)
//   locked     out  1      1 while tracking a consistent stream
//   err_pulse  out  1      1-cycle pulse on a detected mismatch
//   err_flag   out  1      sticky error flag
//   bounce_top out  1      1-cycle pulse: turned down at MAX
//   bounce_bot out  1      1-cycle pulse: turned up at 0
//   lap_cnt    out  LAP_W  completed laps, saturating
//   err_cnt    out  ERR_W  mismatch count, saturating (PP_MON_ERR_CNT_EN only)
// ---------------------------------------------------------------------------
module ping_pong_monitor #(
  parameter int WIDTH = 4,
  parameter int LAP_W = 8,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             direction,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic             err_flag,
  output logic             bounce_top,
  output logic             bounce_bot,
  output logic [LAP_W-1:0] lap_cnt
`ifdef PP_MON_ERR_CNT_EN
  ,
  output logic [ERR_W-1:0] err_cnt
`endif
);

  localparam logic [WIDTH-1:0] MAX_V   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE_V   = WIDTH'(1);
  localparam logic [LAP_W-1:0] LAP_MAX = {LAP_W{1'b1}};

  // ACQ and ERR both recapture the next sample. They stay distinct so the
  // state stays readable in waveforms.
  typedef enum logic [1:0] {
    S_ACQ,
    S_TRACK,
    S_ERR
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_ref_v;
  logic             r_ref_d;

  logic [WIDTH-1:0] w_exp_v;
  logic             w_exp_d;
  logic             w_check;
  logic             w_match;
  logic             w_err;
  logic             w_top;
  logic             w_bot;

  // Predicts the next sample. The count turns at the end points, so the
  // arithmetic never wraps.
  always_comb begin
    // NOTE: every signal gets a default before the branches, so no path can
    // leave one unassigned and infer a latch.
    w_exp_v = r_ref_v - ONE_V;
    w_exp_d = 1'b0;
    if ((r_ref_d && (r_ref_v != MAX_V)) || (!r_ref_d && (r_ref_v == '0))) begin
      w_exp_v = r_ref_v + ONE_V;
      w_exp_d = 1'b1;
    end
  end

  assign w_check = enable && (r_state == S_TRACK);
  assign w_match = (cnt_in == w_exp_v) && (direction == w_exp_d);
  assign w_err   = w_check && !w_match;
  // A matching sample whose direction differs from the reference is a turn.
  assign w_top   = w_check && w_match && (w_exp_d != r_ref_d) && !w_exp_d;
  assign w_bot   = w_check && w_match && (w_exp_d != r_ref_d) &&  w_exp_d;

  // NOTE: all state is updated with non-blocking assignments, so every
  // right-hand side sees values from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_ACQ;
      r_ref_v    <= '0;
      r_ref_d    <= 1'b0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_flag   <= 1'b0;
      bounce_top <= 1'b0;
      bounce_bot <= 1'b0;
      lap_cnt    <= '0;
    end else begin
      err_pulse  <= w_err;
      bounce_top <= w_top;
      bounce_bot <= w_bot;

      if (enable) begin
        case (r_state)
          S_ACQ, S_ERR: begin
            r_ref_v <= cnt_in;
            r_ref_d <= direction;
            r_state <= S_TRACK;
            locked  <= 1'b1;
          end
          S_TRACK: begin
            if (w_match) begin
              r_ref_v <= cnt_in;
              r_ref_d <= direction;
            end else begin
              // Keep the old reference. The next sample is recaptured.
              r_state <= S_ERR;
              locked  <= 1'b0;
            end
          end
          default: begin
            r_state <= S_ACQ;
            locked  <= 1'b0;
          end
        endcase
      end

      // clr takes priority over a same-cycle event. Pulses still fire.
      if (clr) begin
        err_flag <= 1'b0;
        lap_cnt  <= '0;
      end else begin
        if (w_err) begin
          err_flag <= 1'b1;
        end
        if (w_bot && (lap_cnt != LAP_MAX)) begin
          lap_cnt <= lap_cnt + LAP_W'(1);
        end
      end
    end
  end

`ifdef PP_MON_ERR_CNT_EN
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      err_cnt <= '0;
    end else if (w_err && (err_cnt != ERR_MAX)) begin
      err_cnt <= err_cnt + ERR_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_ping_pong_monitor.sv
// ---------------------------------------------------------------------------
// tb_ping_pong_monitor
//   Self-checking bench for ping_pong_monitor (WIDTH=4, LAP_W=2, ERR_W=8).
//   A behavioural model follows the stream rules with plain integers. One
//   compare process checks every DUT output against the model on each
//   falling edge. Directed scenarios add hand-computed literal expectations.
//   A randomized phase follows.
// ---------------------------------------------------------------------------
module tb_ping_pong_monitor;

  localparam int WIDTH  = 4;
  localparam int LAP_W  = 2;
  localparam int ERR_W  = 8;
  localparam int MAXV   = 15;
  localparam int LAPMAX = 3;
  localparam int ERRMAX = 255;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic             direction = 1'b0;
  logic [WIDTH-1:0] cnt_in = '0;
  logic             clr = 1'b0;
  logic             locked;
  logic             err_pulse;
  logic             err_flag;
  logic             bounce_top;
  logic             bounce_bot;
  logic [LAP_W-1:0] lap_cnt;
`ifdef PP_MON_ERR_CNT_EN
  logic [ERR_W-1:0] err_cnt;
`endif

  ping_pong_monitor #(
    .WIDTH(WIDTH),
    .LAP_W(LAP_W),
    .ERR_W(ERR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .direction (direction),
    .cnt_in    (cnt_in),
    .clr       (clr),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_flag  (err_flag),
    .bounce_top(bounce_top),
    .bounce_bot(bounce_bot),
    .lap_cnt   (lap_cnt)
`ifdef PP_MON_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks whether a reference is held and what it is. A mismatch drops the
  // reference, so the next enabled sample is simply taken as the new one.
  bit m_valid = 1'b0;
  bit m_track, m_locked, m_errp, m_flag, m_top, m_bot;
  int m_v, m_d, m_lap, m_errc;

  always @(posedge clk) begin
    int ev, ed;
    if (rst) begin
      m_track = 0; m_v = 0; m_d = 0;
      m_errp = 0; m_flag = 0; m_top = 0; m_bot = 0; m_lap = 0; m_errc = 0;
      m_valid = 1;
    end else begin
      m_errp = 0; m_top = 0; m_bot = 0;
      if (enable) begin
        if (!m_track) begin
          m_v = int'(cnt_in); m_d = int'(direction); m_track = 1;
        end else begin
          if ((m_d == 1 && m_v < MAXV) || (m_d == 0 && m_v == 0)) begin
            ev = m_v + 1; ed = 1;
          end else begin
            ev = m_v - 1; ed = 0;
          end
          if (int'(cnt_in) == ev && int'(direction) == ed) begin
            if (ed != m_d) begin
              if (ed == 1) begin
                m_bot = 1;
                if (m_lap < LAPMAX) m_lap++;
              end else begin
                m_top = 1;
              end
            end
            m_v = ev; m_d = ed;
          end else begin
            m_errp = 1; m_flag = 1; m_track = 0;
            if (m_errc < ERRMAX) m_errc++;
          end
        end
      end
      if (clr) begin
        m_flag = 0; m_lap = 0; m_errc = 0;
      end
    end
    m_locked = m_track;
  end

  // ---------------- compare process ----------------
  int cnt_top = 0;
  int cnt_bot = 0;
  int cnt_errp = 0;

  always @(negedge clk) begin
    if (m_valid) begin
      check("locked",     locked,     m_locked);
      check("err_pulse",  err_pulse,  m_errp);
      check("err_flag",   err_flag,   m_flag);
      check("bounce_top", bounce_top, m_top);
      check("bounce_bot", bounce_bot, m_bot);
      check("lap_cnt",    lap_cnt,    m_lap);
`ifdef PP_MON_ERR_CNT_EN
      check("err_cnt",    err_cnt,    m_errc);
`endif
      cnt_top  += int'(bounce_top);
      cnt_bot  += int'(bounce_bot);
      cnt_errp += int'(err_pulse);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Drives one clock of inputs. Returns 1 time unit after the rising edge,
  // so the outputs for that sample can be read.
  task automatic cyc(input bit en, input int v, input bit d, input bit c, input bit r);
    logic [31:0] vv;
    @(negedge clk);
    vv        = v;
    enable    = en;
    cnt_in    = vv[WIDTH-1:0];
    direction = d;
    clr       = c;
    rst       = r;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v, input bit d);
    cyc(1'b1, v, d, 1'b0, 1'b0);
  endtask

  // From reference 1u: up to 15, down to 0, then 1u (one bottom bounce).
  task automatic lap_from_one(input bit toggle_en);
    for (int v = 2; v <= MAXV; v++) begin
      send(v, 1'b1);
      if (toggle_en) cyc(1'b0, $urandom_range(15), 1'($urandom_range(1)), 1'b0, 1'b0);
    end
    for (int v = MAXV - 1; v >= 0; v--) begin
      send(v, 1'b0);
      if (toggle_en) cyc(1'b0, $urandom_range(15), 1'($urandom_range(1)), 1'b0, 1'b0);
    end
    send(1, 1'b1);
    if (toggle_en) cyc(1'b0, $urandom_range(15), 1'($urandom_range(1)), 1'b0, 1'b0);
  endtask

  int t0, b0, e0;
  int gen_v, gen_d;

  initial begin
    // ---- reset ----
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
    check("rst_locked", locked, 0);
    check("rst_lap", lap_cnt, 0);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);

    // ---- test 1: one clean lap ----
    t0 = cnt_top; b0 = cnt_bot; e0 = cnt_errp;
    send(0, 1'b1);
    check("t1_locked_first", locked, 1);
    send(1, 1'b1);
    lap_from_one(1'b0);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
    check("t1_tops", cnt_top - t0, 1);
    check("t1_bots", cnt_bot - b0, 1);
    check("t1_errs", cnt_errp - e0, 0);
    check("t1_lap", lap_cnt, 1);

    // ---- test 2: value jump 5u -> 7u ----
    for (int v = 2; v <= 5; v++) send(v, 1'b1);
    send(7, 1'b1);
    check("t2_err_pulse", err_pulse, 1);
    check("t2_err_flag", err_flag, 1);
    check("t2_unlocked", locked, 0);
    send(8, 1'b1);
    check("t2_relock", locked, 1);
    check("t2_no_2nd_err", err_pulse, 0);

    // ---- test 3: direction glitch at 9u -> 10d ----
    send(9, 1'b1);
    send(10, 1'b0);
    check("t3_err_pulse", err_pulse, 1);
    check("t3_no_top", bounce_top, 0);
    send(11, 1'b1);
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
    check("t3_clr_flag", err_flag, 0);

    // ---- test 4: enable toggling over a full lap, from reset ----
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
    t0 = cnt_top; b0 = cnt_bot; e0 = cnt_errp;
    send(0, 1'b1);
    cyc(1'b0, 7, 1'b0, 1'b0, 1'b0);
    send(1, 1'b1);
    cyc(1'b0, 3, 1'b1, 1'b0, 1'b0);
    lap_from_one(1'b1);
    check("t4_tops", cnt_top - t0, 1);
    check("t4_bots", cnt_bot - b0, 1);
    check("t4_errs", cnt_errp - e0, 0);
    check("t4_lap", lap_cnt, 1);

    // ---- test 5: saturation and clr beating a bounce ----
    for (int i = 0; i < 4; i++) lap_from_one(1'b0);
    check("t5_lap_sat", lap_cnt, 3);
    for (int v = 2; v <= MAXV; v++) send(v, 1'b1);
    for (int v = MAXV - 1; v >= 0; v--) send(v, 1'b0);
    cyc(1'b1, 1, 1'b1, 1'b1, 1'b0);
    check("t5_clr_lap", lap_cnt, 0);
    check("t5_clr_bot", bounce_bot, 1);

    // ---- test 6: three errors, then reset mid-lap ----
    send(2, 1'b1);
    send(9, 1'b1);
    send(3, 1'b1);
    send(4, 1'b1);
    send(0, 1'b0);
    send(5, 1'b1);
    send(6, 1'b0);
    check("t6_flag", err_flag, 1);
`ifdef PP_MON_ERR_CNT_EN
    check("t6_err_cnt", err_cnt, 3);
`endif
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
    check("t6_rst_locked", locked, 0);
    check("t6_rst_flag", err_flag, 0);
`ifdef PP_MON_ERR_CNT_EN
    check("t6_rst_err_cnt", err_cnt, 0);
`endif
    send(11, 1'b0);
    check("t6_first_no_err", err_pulse, 0);
    check("t6_first_locked", locked, 1);

    // ---- randomized phase ----
    gen_v = 11; gen_d = 0;
    for (int i = 0; i < 3000; i++) begin
      int r, jv, jd;
      bit en, c, rs;
      r  = $urandom_range(99);
      en = (r < 70);
      c  = ($urandom_range(99) < 3);
      rs = ($urandom_range(199) < 1);
      if (en) begin
        // Advance the true counter, then sometimes send a corrupt sample.
        if ((gen_d == 1 && gen_v < MAXV) || (gen_d == 0 && gen_v == 0)) begin
          gen_v++; gen_d = 1;
        end else begin
          gen_v--; gen_d = 0;
        end
        if ($urandom_range(99) < 2) begin
          gen_v = $urandom_range(MAXV); gen_d = $urandom_range(1);
        end
        if ($urandom_range(99) < 5) begin
          jv = $urandom_range(MAXV); jd = $urandom_range(1);
          cyc(1'b1, jv, 1'(jd), c, rs);
        end else begin
          cyc(1'b1, gen_v, 1'(gen_d), c, rs);
        end
      end else begin
        cyc(1'b0, $urandom_range(MAXV), 1'($urandom_range(1)), c, rs);
      end
    end

    cyc(1'b0, 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
